// File: rtl/alu181_pkg.sv
// Shared constants for the 74181-style ALU: mode encodings and the 16 function-select codes.
package alu181_pkg;

  localparam logic ALU_MODE_LOGIC = 1'b1;
  localparam logic ALU_MODE_ARITH = 1'b0;

  // Names follow the logic-mode (M=1) function of each select code.
  typedef enum logic [3:0] {
    SEL_NOT_A      = 4'h0,
    SEL_NOR        = 4'h1,
    SEL_NOTA_AND_B = 4'h2,
    SEL_ZERO       = 4'h3,
    SEL_NAND       = 4'h4,
    SEL_NOT_B      = 4'h5,
    SEL_XOR        = 4'h6,
    SEL_A_AND_NOTB = 4'h7,
    SEL_NOTA_OR_B  = 4'h8,
    SEL_XNOR       = 4'h9,
    SEL_B          = 4'hA,
    SEL_AND        = 4'hB,
    SEL_ONES       = 4'hC,
    SEL_A_OR_NOTB  = 4'hD,
    SEL_OR         = 4'hE,
    SEL_A          = 4'hF
  } alu_sel_e;

endpackage

// File: rtl/alu_181_comb.sv
// Combinational core of the 74181-style ALU: logic table for M=1, X+Y+Cn sum for M=0.
module alu_181_comb
  import alu181_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             M,
  input  logic             Cn,
  input  logic [3:0]       Sel,
  output logic [WIDTH-1:0] F,
  output logic             Cout
);

  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] logic_f;

  // Per-bit generate/propagate terms reproduce the whole 74181 arithmetic table.
  always_comb begin
    x   = A | (B & {WIDTH{Sel[0]}}) | (~B & {WIDTH{Sel[1]}});
    y   = (A & B & {WIDTH{Sel[3]}}) | (A & ~B & {WIDTH{Sel[2]}});
    sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, Cn};
  end

  always_comb begin
    logic_f = '0;
    case (Sel)
      SEL_NOT_A:      logic_f = ~A;
      SEL_NOR:        logic_f = ~(A | B);
      SEL_NOTA_AND_B: logic_f = ~A & B;
      SEL_ZERO:       logic_f = '0;
      SEL_NAND:       logic_f = ~(A & B);
      SEL_NOT_B:      logic_f = ~B;
      SEL_XOR:        logic_f = A ^ B;
      SEL_A_AND_NOTB: logic_f = A & ~B;
      SEL_NOTA_OR_B:  logic_f = ~A | B;
      SEL_XNOR:       logic_f = ~(A ^ B);
      SEL_B:          logic_f = B;
      SEL_AND:        logic_f = A & B;
      SEL_ONES:       logic_f = '1;
      SEL_A_OR_NOTB:  logic_f = A | ~B;
      SEL_OR:         logic_f = A | B;
      SEL_A:          logic_f = A;
      default:        logic_f = '0;
    endcase
  end

  always_comb begin
    if (M == ALU_MODE_LOGIC) begin
      F    = logic_f;
      Cout = 1'b0;
    end else begin
      F    = sum[WIDTH-1:0];
      Cout = sum[WIDTH];
    end
  end

endmodule

// File: rtl/alu_181.sv
// Registered 74181-style ALU execute stage: one-cycle latency, flags derived from the captured result.
module alu_181
  import alu181_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             M,
  input  logic             Cn,
  input  logic [3:0]       Sel,
  output logic [WIDTH-1:0] F,
  output logic             Cout,
  output logic             AeqB,
  output logic             Zero,
  output logic             out_valid
);

  logic [WIDTH-1:0] comb_f;
  logic             comb_cout;

  alu_181_comb #(.WIDTH(WIDTH)) u_comb (
    .A    (A),
    .B    (B),
    .M    (M),
    .Cn   (Cn),
    .Sel  (Sel),
    .F    (comb_f),
    .Cout (comb_cout)
  );

  // Result and flags hold while in_valid is low; only out_valid follows every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      F         <= '0;
      Cout      <= 1'b0;
      AeqB      <= 1'b0;
      Zero      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        F    <= comb_f;
        Cout <= comb_cout;
        AeqB <= &comb_f;
        Zero <= (comb_f == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_181.sv
// Directed and random checks of alu_181 using an expected-result queue popped one cycle after each capture.
module tb_alu_181;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] A, B;
  logic         M, Cn;
  logic [3:0]   Sel;
  logic [W-1:0] F;
  logic         Cout, AeqB, Zero, out_valid;

  typedef struct packed {
    logic [W-1:0] f;
    logic         cout;
    logic         aeqb;
    logic         zero;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] last_f;

  alu_181 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .A(A), .B(B), .M(M), .Cn(Cn), .Sel(Sel),
    .F(F), .Cout(Cout), .AeqB(AeqB), .Zero(Zero), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: logic table as listed, arithmetic from the X+Y+Cn formula.
  function automatic logic [W:0] model(input logic [W-1:0] a, b, input logic m, cn,
                                        input logic [3:0] s);
    logic [W-1:0] x, y, r;
    if (m) begin
      case (s)
        4'h0: r = ~a;        4'h1: r = ~(a | b);
        4'h2: r = ~a & b;    4'h3: r = '0;
        4'h4: r = ~(a & b);  4'h5: r = ~b;
        4'h6: r = a ^ b;     4'h7: r = a & ~b;
        4'h8: r = ~a | b;    4'h9: r = ~(a ^ b);
        4'hA: r = b;         4'hB: r = a & b;
        4'hC: r = '1;        4'hD: r = a | ~b;
        4'hE: r = a | b;     default: r = a;
      endcase
      return {1'b0, r};
    end
    x = a;
    if (s[0]) x = x | b;
    if (s[1]) x = x | ~b;
    y = '0;
    if (s[3]) y = y | (a & b);
    if (s[2]) y = y | (a & ~b);
    return {1'b0, x} + {1'b0, y} + (W + 1)'(cn);
  endfunction

  task automatic step(input string tag, input logic [W-1:0] a, b, input logic m, cn,
                      input logic [3:0] s, input logic [W-1:0] ef, input logic ec);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1; A = a; B = b; M = m; Cn = cn; Sel = s;
    sb.push_back('{f: ef, cout: ec, aeqb: &ef, zero: (ef == '0)});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_F"}, 32'(F), 32'(e.f));
      chk({tag, "_Cout"}, 32'(Cout), 32'(e.cout));
      chk({tag, "_AeqB"}, 32'(AeqB), 32'(e.aeqb));
      chk({tag, "_Zero"}, 32'(Zero), 32'(e.zero));
      chk({tag, "_vld"}, 32'(out_valid), 32'd1);
      last_f = e.f;
    end
  endtask

  initial begin
    logic [W:0] r;
    logic [W-1:0] ra, rb;
    logic rcn;
    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; M = 1'b0; Cn = 1'b0; Sel = '0;
    #1;
    chk("rst0_F", 32'(F), 32'd0);
    chk("rst0_vld", 32'(out_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    step("pre_rst", 8'h85, 8'hAA, 1'b1, 1'b0, 4'hC, 8'hFF, 1'b0);
    step("pre_rst2", 8'hFF, 8'h01, 1'b0, 1'b0, 4'h9, 8'h00, 1'b1);
    step("pre_rst3", 8'h85, 8'hAA, 1'b1, 1'b0, 4'hC, 8'hFF, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; A = 8'hFF; B = 8'h01; M = 1'b0; Sel = 4'h9;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_F", 32'(F), 32'd0);
    chk("rst_Cout", 32'(Cout), 32'd0);
    chk("rst_AeqB", 32'(AeqB), 32'd0);
    chk("rst_Zero", 32'(Zero), 32'd0);
    chk("rst_vld", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_pend_F", 32'(F), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    step("a_selF", 8'h85, 8'hAA, 1'b0, 1'b0, 4'hF, 8'h84, 1'b1);
    step("a_sel1", 8'h85, 8'hAA, 1'b0, 1'b0, 4'h1, 8'hAF, 1'b0);
    step("a_selB", 8'h85, 8'hAA, 1'b0, 1'b0, 4'hB, 8'h7F, 1'b1);
    step("a_sel0", 8'h85, 8'hAA, 1'b0, 1'b0, 4'h0, 8'h85, 1'b0);
    step("l_selB", 8'h85, 8'hAA, 1'b1, 1'b0, 4'hB, 8'h80, 1'b0);
    step("l_selF", 8'h85, 8'hAA, 1'b1, 1'b0, 4'hF, 8'h85, 1'b0);
    step("l_sel8", 8'h85, 8'hAA, 1'b1, 1'b0, 4'h8, 8'hFA, 1'b0);
    step("l_selC", 8'h85, 8'hAA, 1'b1, 1'b1, 4'hC, 8'hFF, 1'b0);
    step("l_sel3", 8'h85, 8'hAA, 1'b1, 1'b1, 4'h3, 8'h00, 1'b0);
    step("wrap_c0", 8'hFF, 8'h01, 1'b0, 1'b0, 4'h9, 8'h00, 1'b1);
    step("wrap_c1", 8'hFF, 8'h01, 1'b0, 1'b1, 4'h9, 8'h01, 1'b1);
    step("sub", 8'h85, 8'hAA, 1'b0, 1'b1, 4'h6, 8'hDB, 1'b0);

    @(negedge clk);
    in_valid = 1'b0; A = 8'h12; Sel = 4'hF; M = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_F", 32'(F), 32'(last_f));
    chk("hold_vld", 32'(out_valid), 32'd0);
    chk("hold_Cout", 32'(Cout), 32'd0);

    for (int i = 0; i < 1000; i++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      rcn = 1'($urandom);
      r   = model(ra, rb, i[5], rcn, i[3:0] ^ 4'(i >> 4));
      step("rand", ra, rb, i[5], rcn, i[3:0] ^ 4'(i >> 4), r[W-1:0], r[W]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
